// File: rtl/vram_pkg.sv
// vram_pkg: shared defaults, channel indices and controller state for the multi-channel VRAM.
package vram_pkg;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_ADDR_W     = 16;
  localparam int DEF_DEPTH_LOG2 = 15;
  localparam int CH_CPU = 0;
  localparam int CH_BG  = 1;
  localparam int CH_SPR = 2;
  localparam int CH_DMA = 3;
  typedef enum logic {VS_CLEAR, VS_RUN} vram_state_t;
endpackage

// File: rtl/vram_arb.sv
// vram_arb: one-hot request arbiter, fixed lowest-index priority or round-robin from ptr.
module vram_arb #(
  parameter int NCH    = 4,
  parameter bit ARB_RR = 1'b0
) (
  input  logic           clock,
  input  logic           reset_N,
  input  logic [NCH-1:0] req,
  input  logic           advance,
  output logic [NCH-1:0] gnt
);
  localparam int PW = NCH > 1 ? $clog2(NCH) : 1;
  logic [PW-1:0] ptr, ptr_nxt, k;
  // Scan from farthest to nearest candidate so the nearest requester is assigned last and wins.
  always_comb begin
    gnt = '0;
    ptr_nxt = ptr;
    k = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      k = ARB_RR ? PW'((int'(ptr) + i) % NCH) : PW'(i);
      if (req[k]) begin
        gnt = '0;
        gnt[k] = 1'b1;
        ptr_nxt = k == PW'(NCH - 1) ? '0 : k + 1'b1;
      end
    end
  end
  always_ff @(posedge clock or negedge reset_N)
    if (!reset_N) ptr <= '0;
    else if (advance && |gnt) ptr <= ptr_nxt;
endmodule

// File: rtl/vram_mp.sv
// vram_mp: NCH requesters arbitrated onto one single-port word RAM, with a zero-clear sweep after reset.
module vram_mp
  import vram_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DEPTH_LOG2     = DEF_DEPTH_LOG2,
  parameter int NCH            = 4,
  parameter bit ARB_RR         = 1'b0,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_N,
  input  logic [NCH-1:0]        req,
  input  logic [NCH-1:0]        we,
  input  logic [NCH*ADDR_W-1:0] addr,
  input  logic [NCH*DATA_W-1:0] wdata,
  output logic [NCH-1:0]        gnt,
  output logic [NCH-1:0]        rvalid,
  output logic [DATA_W-1:0]     rdata,
  output logic                  oob_err,
  output logic                  busy
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  vram_state_t state, state_nxt;
  logic [DEPTH_LOG2-1:0] clr_cnt, idx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] a;
  logic [DATA_W-1:0] d;
  logic w, oob, acc;
  // Grants are suppressed while the sweep runs or reset is held, so requests are never queued.
  vram_arb #(.NCH(NCH), .ARB_RR(ARB_RR)) u_arb (
    .clock(clock),
    .reset_N(reset_N),
    .req(req & {NCH{state == VS_RUN && reset_N}}),
    .advance(state == VS_RUN),
    .gnt(gnt)
  );
  always_comb begin
    a = '0;
    d = '0;
    w = 1'b0;
    for (int c = 0; c < NCH; c++)
      if (gnt[c]) begin
        a = addr[c*ADDR_W +: ADDR_W];
        d = wdata[c*DATA_W +: DATA_W];
        w = we[c];
      end
  end
  assign acc = |gnt;
  assign oob = |(a >> DEPTH_LOG2);
  assign idx = a[DEPTH_LOG2-1:0];
  assign busy = state == VS_CLEAR;
  always_comb state_nxt = state == VS_CLEAR && &clr_cnt ? VS_RUN : state;
  always_ff @(posedge clock or negedge reset_N)
    if (!reset_N) begin
      state <= CLEAR_ON_RESET ? VS_CLEAR : VS_RUN;
      clr_cnt <= '0;
      rvalid <= '0;
      rdata <= '0;
      oob_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == VS_CLEAR) clr_cnt <= clr_cnt + 1'b1;
      rvalid <= acc && !w ? gnt : '0;
      oob_err <= acc && oob;
      if (acc && !w) rdata <= oob ? '0 : mem[idx];
    end
  always_ff @(posedge clock)
    if (state == VS_CLEAR) mem[clr_cnt] <= '0;
    else if (acc && w && !oob) mem[idx] <= d;
endmodule

// File: tb/tb_vram_mp.sv
// tb_vram_mp: random and directed checks of vram_mp against a word-array / arbitration-rule model.
module tb_vram_mp;
  logic clock = 1'b0;
  logic rst_a_n, rst_b_n;
  logic [3:0] a_req, a_we, a_gnt, a_rvalid, b_req, b_we, b_gnt, b_rvalid;
  logic [63:0] a_addr, a_wdata, b_addr, b_wdata;
  logic [15:0] a_rdata, b_rdata;
  logic a_oob, a_busy, b_oob, b_busy;
  int n_chk = 0;
  int n_pass = 0;
  logic [15:0] mdl [16];
  logic [3:0] ex_rv;
  logic [15:0] ex_rd;
  logic ex_oob;
  int g_idx = -1;
  int bp = 0;
  always #5 clock = ~clock;
  vram_mp #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(4), .NCH(4), .ARB_RR(1'b0), .CLEAR_ON_RESET(1'b1)) u_a (
    .clock(clock), .reset_N(rst_a_n), .req(a_req), .we(a_we), .addr(a_addr), .wdata(a_wdata),
    .gnt(a_gnt), .rvalid(a_rvalid), .rdata(a_rdata), .oob_err(a_oob), .busy(a_busy)
  );
  vram_mp #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(15), .NCH(4), .ARB_RR(1'b1), .CLEAR_ON_RESET(1'b0)) u_b (
    .clock(clock), .reset_N(rst_b_n), .req(b_req), .we(b_we), .addr(b_addr), .wdata(b_wdata),
    .gnt(b_gnt), .rvalid(b_rvalid), .rdata(b_rdata), .oob_err(b_oob), .busy(b_busy)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++) if (r[(p + i) % 4]) return (p + i) % 4;
    return -1;
  endfunction
  // One run-mode cycle on A: check against the model, then apply the granted access to the model.
  task automatic cycle_a();
    int c, ad;
    @(negedge clock);
    c = -1;
    for (int i = 3; i >= 0; i--) if (a_req[i]) c = i;
    chk("a_gnt", a_gnt, c < 0 ? 0 : 1 << c);
    chk("a_rvalid", a_rvalid, ex_rv);
    chk("a_rdata", a_rdata, ex_rd);
    chk("a_oob", a_oob, ex_oob);
    chk("a_busy", a_busy, 0);
    ex_rv = '0;
    ex_oob = 1'b0;
    if (c >= 0) begin
      ad = int'(a_addr[c*16 +: 16]);
      ex_oob = ad >= 16;
      if (a_we[c]) begin
        if (!ex_oob) mdl[ad] = a_wdata[c*16 +: 16];
      end else begin
        ex_rv = 4'(1 << c);
        ex_rd = ex_oob ? 16'h0 : mdl[ad];
      end
    end
    g_idx = c;
    @(posedge clock); #1;
  endtask
  task automatic sweep_a();
    int nb, ng;
    nb = 0;
    ng = 0;
    a_req = 4'b0001; a_we = '0; a_addr = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (a_busy) begin
        nb++;
        if (a_gnt != 0) ng++;
      end
    end
    chk("a_sweep_len", nb, 16);
    chk("a_sweep_gnt", ng, 0);
    a_req = '0;
    @(posedge clock); #1;
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    ex_rv = '0; ex_rd = '0; ex_oob = 1'b0;
  endtask
  task automatic cycle_b();
    int c;
    @(negedge clock);
    c = rr_pick(b_req, bp);
    chk("b_gnt", b_gnt, c < 0 ? 0 : 1 << c);
    if (c >= 0) bp = (c + 1) % 4;
    g_idx = c;
    @(posedge clock); #1;
  endtask
  initial begin
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    a_req = 4'b0001; a_we = '0; a_addr = '0; a_wdata = '0;
    b_req = '0; b_we = '0; b_addr = '0; b_wdata = '0;
    for (int i = 0; i < 16; i++) u_a.mem[i] = 16'(i * 16'h1111 + 16'h0f0f);
    repeat (2) @(negedge clock);
    chk("rst_gnt", a_gnt, 0);
    chk("rst_rvalid", a_rvalid, 0);
    chk("rst_rdata", a_rdata, 0);
    chk("rst_oob", a_oob, 0);
    chk("rst_busy", a_busy, 1);
    @(posedge clock); #1;
    rst_a_n = 1'b1;
    repeat (7) @(posedge clock);
    #1 rst_a_n = 1'b0;
    chk("mid_rst_busy", a_busy, 1);
    @(posedge clock); #1;
    rst_a_n = 1'b1;
    sweep_a();
    for (int i = 0; i < 16; i++) begin
      a_req = 4'b0001; a_we = '0; a_addr[15:0] = 16'(i);
      cycle_a();
    end
    a_req = 4'b1110; a_we = '0; a_addr = 64'h0003_0002_0001_0000;
    repeat (3) cycle_a();
    a_req = '0;
    cycle_a();
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 4; i++)
        if (i == g_idx || !a_req[i]) begin
          a_req[i] = $urandom_range(0, 2) != 0;
          a_we[i] = 1'($urandom_range(0, 1));
          a_addr[i*16 +: 16] = 16'($urandom_range(0, 19));
          a_wdata[i*16 +: 16] = 16'($urandom);
        end
      cycle_a();
    end
    a_req = 4'b0001; a_we = '0; a_addr = 64'h3;
    cycle_a();
    a_req = '0;
    rst_a_n = 1'b0;
    #1;
    chk("rst_rd_rvalid", a_rvalid, 0);
    chk("rst_rd_rdata", a_rdata, 0);
    chk("rst_rd_busy", a_busy, 1);
    @(posedge clock); #1;
    rst_a_n = 1'b1;
    sweep_a();
    // DUT B: round-robin, full 15-bit depth, no clear sweep.
    @(posedge clock); #1;
    rst_b_n = 1'b1;
    chk("b_busy", b_busy, 0);
    b_req = 4'b1111;
    repeat (5) cycle_b();
    for (int n = 0; n < 100; n++) begin
      for (int i = 0; i < 4; i++)
        if (i == g_idx || !b_req[i]) b_req[i] = 1'($urandom_range(0, 1));
      cycle_b();
    end
    b_req = 4'b0001; b_we = 4'b0001; b_addr[15:0] = 16'h0123; b_wdata[15:0] = 16'hbeef;
    cycle_b();
    chk("b_wr_rvalid", b_rvalid, 0);
    b_req = 4'b0010; b_we = '0; b_addr[31:16] = 16'h0123;
    cycle_b();
    chk("b_rd_rvalid", b_rvalid, 4'b0010);
    chk("b_rd_rdata", b_rdata, 16'hbeef);
    b_req = 4'b0001; b_we = 4'b0001; b_addr[15:0] = 16'h0000; b_wdata[15:0] = 16'h5555;
    cycle_b();
    b_req = 4'b1000; b_we = 4'b1000; b_addr[63:48] = 16'h8000; b_wdata[63:48] = 16'h1234;
    cycle_b();
    chk("b_oob_wr", b_oob, 1);
    chk("b_oob_wr_rv", b_rvalid, 0);
    b_req = 4'b0001; b_we = '0; b_addr[15:0] = 16'h0000;
    cycle_b();
    chk("b_oob_clr", b_oob, 0);
    chk("b_rd0_rvalid", b_rvalid, 4'b0001);
    chk("b_rd0_rdata", b_rdata, 16'h5555);
    b_addr[15:0] = 16'h8000;
    cycle_b();
    chk("b_oob_rd_rvalid", b_rvalid, 4'b0001);
    chk("b_oob_rd_rdata", b_rdata, 16'h0000);
    chk("b_oob_rd_err", b_oob, 1);
    b_addr[15:0] = 16'h0000;
    cycle_b();
    chk("b_alias_rdata", b_rdata, 16'h5555);
    b_req = '0;
    cycle_b();
    chk("b_idle_rvalid", b_rvalid, 0);
    chk("b_hold_rdata", b_rdata, 16'h5555);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
